// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD_CTRL host side: opcodes and issuer states.
package lcd_pkg;

   localparam logic [3:0] CMD_WRITE       = 4'h0;
   localparam logic [3:0] CMD_SHIFT_UP    = 4'h1;
   localparam logic [3:0] CMD_SHIFT_DOWN  = 4'h2;
   localparam logic [3:0] CMD_SHIFT_LEFT  = 4'h3;
   localparam logic [3:0] CMD_SHIFT_RIGHT = 4'h4;
   localparam logic [3:0] CMD_MAX         = 4'h5;
   localparam logic [3:0] CMD_MIN         = 4'h6;
   localparam logic [3:0] CMD_AVERAGE     = 4'h7;
   localparam logic [3:0] CMD_ROTATE_CCW  = 4'h8;
   localparam logic [3:0] CMD_ROTATE_CW   = 4'h9;
   localparam logic [3:0] CMD_MIRROR_X    = 4'hA;
   localparam logic [3:0] CMD_MIRROR_Y    = 4'hB;
   localparam logic [3:0] CMD_MAX_LEGAL   = 4'hB;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_WAIT_RDY,
      ST_ISSUE,
      ST_GUARD,
      ST_WAIT_DONE,
      ST_FINISH
   } issuer_state_t;

   // Opcodes above Mirror Y have no meaning to LCD_CTRL and are never issued.
   function automatic logic is_illegal(input logic [3:0] op);
      return op > CMD_MAX_LEGAL;
   endfunction

endpackage

// File: rtl/lcd_cmd_issuer.sv
// Host-side command issuer: walks the command ROM and hands one opcode at a
// time to LCD_CTRL over the cmd/cmd_valid/busy handshake, then waits for done.
module lcd_cmd_issuer
   import lcd_pkg::*;
#(
   parameter int N_CMD  = 46,
   parameter int CMD_AW = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              cmd_rom_rd,
   output logic [CMD_AW-1:0] cmd_rom_a,
   input  logic [3:0]        cmd_rom_q,
   input  logic              busy,
   input  logic              done,
   output logic [3:0]        cmd,
   output logic              cmd_valid,
   output logic [CMD_AW:0]   issued_cnt,
   output logic              seq_done,
   output logic              err_illegal
);

   // ptr is one bit wider than the ROM address so a full-depth ROM can be
   // walked without the address wrapping before the end test fires.
   localparam logic [CMD_AW:0] PTR_ONE    = 1;
   localparam logic [CMD_AW:0] PTR_LAST   = (CMD_AW + 1)'(N_CMD);
   localparam logic [CMD_AW:0] PTR_PENULT = PTR_LAST - PTR_ONE;

   issuer_state_t   state;
   issuer_state_t   state_next;
   logic [CMD_AW:0] ptr;
   logic [3:0]      cmd_r;
   logic            start_ok;
   logic            rom_illegal;

   assign start_ok    = start && ((state == ST_IDLE) || (state == ST_FINISH));
   assign rom_illegal = is_illegal(cmd_rom_q);
   assign cmd_rom_rd  = (state == ST_FETCH);
   assign cmd_rom_a   = ptr[CMD_AW-1:0];

   // Next-state decode; an early done abandons whatever is left of the stream.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_FINISH: begin
            if (start) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            state_next = done ? ST_FINISH : ST_LOAD;
         end
         ST_LOAD: begin
            if (done)
               state_next = ST_FINISH;
            else if (rom_illegal)
               state_next = (ptr == PTR_PENULT) ? ST_WAIT_DONE : ST_FETCH;
            else
               state_next = ST_WAIT_RDY;
         end
         ST_WAIT_RDY: begin
            if (done)
               state_next = ST_FINISH;
            else if (!busy)
               state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if ((cmd_r == CMD_WRITE) || (ptr == PTR_LAST))
               state_next = ST_WAIT_DONE;
            else
               state_next = ST_GUARD;
         end
         ST_GUARD: begin
            state_next = done ? ST_FINISH : ST_FETCH;
         end
         ST_WAIT_DONE: begin
            if (done) state_next = ST_FINISH;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register plus flags decoded from the next state so cmd_valid and
   // seq_done come straight off flops and line up with ISSUE / FINISH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd_valid <= 1'b0;
         seq_done  <= 1'b0;
      end else begin
         state     <= state_next;
         cmd_valid <= (state_next == ST_ISSUE);
         seq_done  <= (state_next == ST_FINISH);
      end
   end

   // Datapath: ROM pointer, fetched opcode, issued opcode, counters and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr         <= '0;
         cmd_r       <= 4'h0;
         cmd         <= 4'h0;
         issued_cnt  <= '0;
         err_illegal <= 1'b0;
      end else begin
         if (start_ok) begin
            ptr         <= '0;
            issued_cnt  <= '0;
            err_illegal <= 1'b0;
         end
         if (state == ST_LOAD) begin
            cmd_r <= cmd_rom_q;
            ptr   <= ptr + PTR_ONE;
            if (rom_illegal) err_illegal <= 1'b1;
         end
         if (state_next == ST_ISSUE) begin
            cmd        <= cmd_r;
            issued_cnt <= issued_cnt + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer with a 4-entry ROM and a behavioural
// LCD_CTRL stand-in driving busy/done from the initial block.
module tb_lcd_cmd_issuer;
   import lcd_pkg::*;

   localparam int CMD_AW = 6;
   localparam int N_CMD  = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              cmd_rom_rd;
   logic [CMD_AW-1:0] cmd_rom_a;
   logic [3:0]        cmd_rom_q = 4'h0;
   logic              busy = 1'b0;
   logic              done = 1'b0;
   logic [3:0]        cmd;
   logic              cmd_valid;
   logic [CMD_AW:0]   issued_cnt;
   logic              seq_done;
   logic              err_illegal;

   logic [3:0] rom_mem [0:63];
   int checks = 0;
   int errors = 0;
   logic prev_valid = 1'b0;

   typedef struct {
      logic [15:0] rom;
      int          n_exp;
      logic [15:0] exp_cmd;
      logic [31:0] exp_time;
      logic [6:0]  exp_cnt;
      logic        exp_err;
   } vec_t;

   vec_t vecs [5];
   logic [3:0] got_cmd [8];
   int         got_time [8];
   int         got_n;

   lcd_cmd_issuer #(.N_CMD(N_CMD), .CMD_AW(CMD_AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .cmd_rom_rd(cmd_rom_rd), .cmd_rom_a(cmd_rom_a), .cmd_rom_q(cmd_rom_q),
      .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
      .issued_cnt(issued_cnt), .seq_done(seq_done), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   // Synchronous command ROM with one cycle of read latency.
   always @(posedge clk) begin
      if (cmd_rom_rd) cmd_rom_q <= rom_mem[cmd_rom_a];
   end

   // Handshake watchdog: a strobe must never repeat back to back or overlap busy.
   always @(negedge clk) begin
      #1;
      if (cmd_valid) begin
         checks++;
         if (busy || prev_valid) begin
            errors++;
            $display("[TB] FAIL handshake cmd_valid=1 busy=%0b prev_valid=%0b required busy=0 prev_valid=0",
                     busy, prev_valid);
         end
      end
      prev_valid = cmd_valid;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic loadRom(input logic [15:0] r);
      for (int i = 0; i < 64; i++) rom_mem[i] = 4'h0;
      for (int i = 0; i < 4; i++) rom_mem[i] = r[4*i +: 4];
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; done = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Leaves the caller at the first negedge after the start edge (FETCH).
   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitPulse(input string name, input int limit, output int dt);
      dt = 0;
      do begin
         @(negedge clk);
         dt++;
      end while (!cmd_valid && dt < limit);
      if (!cmd_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // One table row: run a whole stream with busy low, then answer with done.
   task automatic applyStimulus(input vec_t v);
      loadRom(v.rom);
      got_n = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (cmd_valid) begin
            if (got_n < 8) begin
               got_cmd[got_n]  = cmd;
               got_time[got_n] = n;
            end
            got_n++;
         end
         @(negedge clk);
      end
      checkOutput("n_pulses", 32'(got_n), 32'(v.n_exp));
      for (int i = 0; i < v.n_exp && i < got_n; i++) begin
         checkOutput("cmd_value", 32'(got_cmd[i]), 32'(v.exp_cmd[4*i +: 4]));
         checkOutput("cmd_time", 32'(got_time[i]), 32'(v.exp_time[8*i +: 8]));
      end
      checkOutput("seq_done_wait", 32'(seq_done), 32'd0);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checkOutput("seq_done", 32'(seq_done), 32'd1);
      checkOutput("issued_cnt", 32'(issued_cnt), 32'(v.exp_cnt));
      checkOutput("err_illegal", 32'(err_illegal), 32'(v.exp_err));
   endtask

   initial begin
      int dt;
      int cnt;

      vecs[0] = '{rom: {4'h0,4'h7,4'h4,4'h1}, n_exp: 4, exp_cmd: {4'h0,4'h7,4'h4,4'h1},
                  exp_time: {8'd19,8'd14,8'd9,8'd4}, exp_cnt: 7'd4, exp_err: 1'b0};
      vecs[1] = '{rom: {4'h0,4'h3,4'hD,4'h2}, n_exp: 3, exp_cmd: {4'h0,4'h0,4'h3,4'h2},
                  exp_time: {8'd0,8'd16,8'd11,8'd4}, exp_cnt: 7'd3, exp_err: 1'b1};
      vecs[2] = '{rom: {4'hA,4'h9,4'h0,4'h5}, n_exp: 2, exp_cmd: {4'h0,4'h0,4'h0,4'h5},
                  exp_time: {8'd0,8'd0,8'd9,8'd4}, exp_cnt: 7'd2, exp_err: 1'b0};
      vecs[3] = '{rom: {4'hF,4'hB,4'h8,4'h3}, n_exp: 3, exp_cmd: {4'h0,4'hB,4'h8,4'h3},
                  exp_time: {8'd0,8'd14,8'd9,8'd4}, exp_cnt: 7'd3, exp_err: 1'b1};
      vecs[4] = '{rom: {4'h2,4'h6,4'hE,4'hC}, n_exp: 2, exp_cmd: {4'h0,4'h0,4'h2,4'h6},
                  exp_time: {8'd0,8'd0,8'd13,8'd8}, exp_cnt: 7'd2, exp_err: 1'b1};

      loadRom({4'h0,4'h7,4'h4,4'h1});
      repeat (2) @(negedge clk);
      checkOutput("rst_cmd_rom_rd", 32'(cmd_rom_rd), 32'd0);
      checkOutput("rst_cmd_rom_a", 32'(cmd_rom_a), 32'd0);
      checkOutput("rst_cmd", 32'(cmd), 32'd0);
      checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      checkOutput("rst_issued_cnt", 32'(issued_cnt), 32'd0);
      checkOutput("rst_seq_done", 32'(seq_done), 32'd0);
      checkOutput("rst_err_illegal", 32'(err_illegal), 32'd0);
      reset = 1'b0;

      // Table rows chain from FINISH, so each start also proves the flags clear.
      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

      // busy held from reset: nothing may issue until it drops.
      busy = 1'b1;
      loadRom({4'h0,4'h7,4'h4,4'h1});
      doReset();
      pulseStart();
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (cmd_valid) cnt++;
      end
      checkOutput("stall_no_valid", 32'(cnt), 32'd0);
      busy = 1'b0;
      @(negedge clk);
      checkOutput("stall_release_valid", 32'(cmd_valid), 32'd1);
      checkOutput("stall_release_cmd", 32'(cmd), 32'h1);

      // busy raised the cycle after each strobe for 4 cycles: 6-cycle spacing.
      doReset();
      pulseStart();
      for (int i = 0; i < 4; i++) begin
         waitPulse("busy_pulse", 30, dt);
         checkOutput("busy_pulse_cmd", 32'(cmd), 32'(rom_mem[i]));
         checkOutput("busy_pulse_dt", 32'(dt), (i == 0) ? 32'd3 : 32'd1);
         if (i < 3) begin
            @(negedge clk);
            busy = 1'b1;
            repeat (4) @(negedge clk);
            busy = 1'b0;
         end
      end
      checkOutput("busy_pulse_cnt", 32'(issued_cnt), 32'd4);

      // Stray start mid-stream is ignored; reset while stalled clears everything.
      doReset();
      pulseStart();
      checkOutput("fetch_rd", 32'(cmd_rom_rd), 32'd1);
      checkOutput("fetch_addr", 32'(cmd_rom_a), 32'd0);
      waitPulse("mid_first", 30, dt);
      waitPulse("mid_second", 30, dt);
      checkOutput("mid_second_cmd", 32'(cmd), 32'h4);
      @(negedge clk);
      busy = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy = 1'b0;
      waitPulse("mid_third", 30, dt);
      checkOutput("ignored_start_cmd", 32'(cmd), 32'h7);
      checkOutput("ignored_start_cnt", 32'(issued_cnt), 32'd3);
      @(negedge clk);
      busy = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
      checkOutput("midrst_cmd", 32'(cmd), 32'd0);
      checkOutput("midrst_issued_cnt", 32'(issued_cnt), 32'd0);
      checkOutput("midrst_cmd_rom_rd", 32'(cmd_rom_rd), 32'd0);
      checkOutput("midrst_cmd_rom_a", 32'(cmd_rom_a), 32'd0);
      reset = 1'b0;
      busy = 1'b0;
      pulseStart();
      waitPulse("restart", 30, dt);
      checkOutput("restart_dt", 32'(dt), 32'd3);
      checkOutput("restart_cmd", 32'(cmd), 32'h1);

      // Early done in GUARD drops the rest; then start beats done in FINISH.
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      checkOutput("early_done_seq", 32'(seq_done), 32'd1);
      checkOutput("early_done_cnt", 32'(issued_cnt), 32'd1);
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (cmd_valid) cnt++;
      end
      checkOutput("early_done_quiet", 32'(cnt), 32'd0);
      start = 1'b1;
      done = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done = 1'b0;
      checkOutput("start_wins_seq", 32'(seq_done), 32'd0);
      checkOutput("start_wins_fetch", 32'(cmd_rom_rd), 32'd1);
      checkOutput("start_wins_cnt", 32'(issued_cnt), 32'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_issuer.md
# lcd_cmd_issuer

Synthesizable host-side command issuer for `LCD_CTRL`: it is the transmitting end of the `cmd`/`cmd_valid`/`busy` handshake that the bench currently drives behaviourally. On `start` it fetches a 4-bit command stream from a synchronous command ROM and issues one command at a time whenever `LCD_CTRL` is not busy. After it issues the Write command (0), or exhausts the stream, it waits for `done` and reports completion. It sits beside `LCD_CTRL` in the top level, replacing the bench's negedge stimulus loop.

## Interface
Parameters:
- `N_CMD`, 46: number of command-ROM entries to issue; legal range 1..2^`CMD_AW`.
- `CMD_AW`, 6: command-ROM address width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or FINISH.
- `cmd_rom_rd`  out  1  command-ROM read strobe.
- `cmd_rom_a`  out  `CMD_AW`  command-ROM address.
- `cmd_rom_q`  in  4  command-ROM data, valid the cycle after `cmd_rom_rd`.
- `busy`  in  1  from `LCD_CTRL`; high means a command must not be issued.
- `done`  in  1  from `LCD_CTRL`; output image has been written to IRAM.
- `cmd`  out  4  command to `LCD_CTRL`.
- `cmd_valid`  out  1  command strobe to `LCD_CTRL`.
- `issued_cnt`  out  `CMD_AW`+1  number of commands issued since `start`.
- `seq_done`  out  1  level; sequence complete.
- `err_illegal`  out  1  sticky; an opcode greater than 4'hB was fetched.

## Operation
- States: IDLE, FETCH, LOAD, WAIT_RDY, ISSUE, GUARD, WAIT_DONE, FINISH.
- IDLE/FINISH + `start` → FETCH. Starting clears `ptr`, `issued_cnt`, `seq_done` and `err_illegal`.
- FETCH: `cmd_rom_rd`=1, `cmd_rom_a`=`ptr` → LOAD.
- LOAD: register `cmd_rom_q` into `cmd_r`; `ptr`++.
  - If `cmd_rom_q` > 4'hB: set `err_illegal`, do not issue, and go to FETCH (or WAIT_DONE if `ptr` was `N_CMD`-1).
  - Otherwise → WAIT_RDY.
- WAIT_RDY: if `busy`=0 → ISSUE; otherwise stay.
- ISSUE: `cmd_valid`=1, `cmd`=`cmd_r`; `issued_cnt`++. The state is exactly one cycle long.
  - If `cmd_r`=0 (Write) or `ptr`=`N_CMD` → WAIT_DONE.
  - Otherwise → GUARD.
- GUARD: one dead cycle so that `LCD_CTRL` can raise `busy` → FETCH.
- WAIT_DONE: on `done`=1 → FINISH.
- FINISH: `seq_done`=1; hold until `start` or `reset`.
- `done` seen in FETCH, LOAD, WAIT_RDY or GUARD → FINISH. Remaining commands are dropped.
- `cmd` holds its last issued value between strobes; it is only meaningful while `cmd_valid`=1.
- Opcodes (from `lcd_pkg`): 0 Write, 1 Shift Up, 2 Shift Down, 3 Shift Left, 4 Shift Right, 5 Max, 6 Min, 7 Average, 8 Rotate CCW, 9 Rotate CW, A Mirror X, B Mirror Y.

## Timing
- Reset values: `cmd_rom_rd`=0, `cmd_rom_a`=0, `cmd`=0, `cmd_valid`=0, `issued_cnt`=0, `seq_done`=0, `err_illegal`=0; state = IDLE.
- `start` at edge t (with `busy` low) → FETCH t+1, LOAD t+2, WAIT_RDY t+3, first `cmd_valid` t+4.
- Steady-state command spacing with `busy` never high: 5 cycles (ISSUE, GUARD, FETCH, LOAD, WAIT_RDY).
- `busy` is sampled only in WAIT_RDY. `cmd_valid` never rises in a cycle where the registered state did not see `busy`=0 the cycle before.
- `cmd_valid` is registered and glitch-free. It is never high for two consecutive cycles.
- `busy` held high from reset (image load in `LCD_CTRL`): the issuer stalls in WAIT_RDY indefinitely; there is no timeout.
- `reset` mid-sequence: all outputs return to reset values on the next edge; no partial command is issued.
- `start` outside IDLE/FINISH is ignored.
- `start` and `done` in the same FINISH cycle: `start` wins.
- `N_CMD`=2^`CMD_AW`: `ptr` is `CMD_AW`+1 bits wide; `cmd_rom_a` = `ptr[CMD_AW-1:0]`, which never wraps before termination.

## Structure
- `lcd_pkg`: opcode localparams `CMD_WRITE`…`CMD_MIRROR_Y`, `CMD_MAX_LEGAL`=4'hB, and the state enum, shared with `LCD_CTRL` and the bench.
- Single module, no sub-module. The command ROM is external; the bench provides a `$readmemh` model with one-cycle read latency.

## Test plan
- Command ROM {1,4,7,0}, `N_CMD`=4, `busy` low after reset: `cmd_valid` pulses with `cmd`=1,4,7,0 five cycles apart, first at `start`+4. `done` after the last pulse → `seq_done`=1, `issued_cnt`=4.
- `busy` high for 20 cycles after reset, then low: no `cmd_valid` during those 20 cycles; the first command is issued the cycle after WAIT_RDY sees `busy`=0.
- `busy` pulses 3 cycles after each command: each next `cmd_valid` occurs no earlier than 1 cycle after `busy` falls; `cmd_valid` never coincides with `busy`=1.
- ROM {2,D,3,0}: `err_illegal`=1; issued `cmd`=2,3,0 only; `issued_cnt`=3.
- Full `cmd3` stream (46 entries, Write last) against `LCD_CTRL`: IRAM matches `tb3_goal`; `issued_cnt`=46.
- `reset` asserted in WAIT_RDY after 10 commands: the next cycle shows all outputs at reset values. A fresh `start` reissues from ROM address 0.
